// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back, write-allocate cache between a word-wide processor port
// and a block-wide memory port, with byte-enable writes, a post-reset invalidate sweep and flush.
module cache_assoc_wb #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WORD_WIDTH  = 32,
  parameter int WAYS        = 2,
  parameter int LINES       = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              proc_cs,
  input  logic                              proc_rw,
  input  logic [ADDR_WIDTH-1:0]             proc_addr,
  input  logic [WORD_WIDTH-1:0]             proc_wdata,
  input  logic [WORD_WIDTH/8-1:0]           proc_be,
  output logic [WORD_WIDTH-1:0]             proc_rdata,
  output logic                              hold_cpu,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              mem_cs,
  output logic                              mem_rw,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [BLOCK_WORDS*WORD_WIDTH-1:0] mem_wdata,
  input  logic [BLOCK_WORDS*WORD_WIDTH-1:0] mem_rdata,
  input  logic                              mem_ack
);
  localparam int OW  = $clog2(BLOCK_WORDS);
  localparam int LW  = $clog2(LINES);
  localparam int TW  = ADDR_WIDTH - LW - OW;
  localparam int BE  = WORD_WIDTH / 8;
  localparam int RW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int OWW = (OW > 0) ? OW : 1;
  localparam int BW  = BLOCK_WORDS * WORD_WIDTH;

  typedef enum logic [2:0] {INIT, IDLE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB} state_t;

  state_t state_q, state_d;

  logic          valid_q [WAYS][LINES];
  logic          dirty_q [WAYS][LINES];
  logic [TW-1:0] tag_q   [WAYS][LINES];
  logic [BW-1:0] data_q  [WAYS][LINES];
  logic [RW-1:0] rr_q    [LINES];

  logic [LW-1:0] init_cnt_q, lat_line_q, fl_line_q;
  logic [TW-1:0] lat_tag_q;
  logic [RW-1:0] vic_way_q, fl_way_q;
  logic          vic_rr_q;

  logic [TW-1:0]         p_tag;
  logic [LW-1:0]         p_line;
  logic [OWW-1:0]        p_off;
  logic                  hit, inv_found, f_last, f_dirty;
  logic [RW-1:0]         hit_way, vic_way;
  logic [WORD_WIDTH-1:0] hit_word;

  function automatic logic [ADDR_WIDTH-1:0] blk_addr(input logic [TW-1:0] t, input logic [LW-1:0] l);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[ADDR_WIDTH-1 -: TW] = t;
    a[OW +: LW] = l;
    return a;
  endfunction

  assign p_tag  = proc_addr[ADDR_WIDTH-1 -: TW];
  assign p_line = proc_addr[OW +: LW];
  generate
    if (OW > 0) begin : g_off
      assign p_off = proc_addr[OW-1:0];
    end else begin : g_no_off
      assign p_off = '0;
    end
  endgenerate

  // Tag match and victim choice: lowest invalid way wins, otherwise the line's round-robin way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][p_line] && tag_q[w][p_line] == p_tag) begin
        hit     = 1'b1;
        hit_way = RW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][p_line]) begin
        inv_found = 1'b1;
        vic_way   = RW'(w);
      end
    end
    if (!inv_found) vic_way = rr_q[p_line];
  end

  assign hit_word = data_q[hit_way][p_line][p_off*WORD_WIDTH +: WORD_WIDTH];
  assign f_last   = (fl_line_q == LW'(LINES - 1)) && (fl_way_q == RW'(WAYS - 1));
  assign f_dirty  = valid_q[fl_way_q][fl_line_q] && dirty_q[fl_way_q][fl_line_q];

  always_comb begin
    state_d    = state_q;
    hold_cpu   = 1'b1;
    flush_done = 1'b0;
    mem_cs     = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      INIT: if (init_cnt_q == LW'(LINES - 1)) state_d = IDLE;
      IDLE: begin
        hold_cpu = flush_req || (proc_cs && !hit);
        if (flush_req) state_d = FLUSH_SCAN;
        else if (proc_cs && !hit)
          state_d = (valid_q[vic_way][p_line] && dirty_q[vic_way][p_line]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_cs    = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = blk_addr(tag_q[vic_way_q][lat_line_q], lat_line_q);
        mem_wdata = data_q[vic_way_q][lat_line_q];
        if (mem_ack) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_cs   = 1'b1;
        mem_addr = blk_addr(lat_tag_q, lat_line_q);
        if (mem_ack) state_d = IDLE;
      end
      FLUSH_SCAN: begin
        if (f_dirty) state_d = FLUSH_WB;
        else if (f_last) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      FLUSH_WB: begin
        mem_cs    = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = blk_addr(tag_q[fl_way_q][fl_line_q], fl_line_q);
        mem_wdata = data_q[fl_way_q][fl_line_q];
        if (mem_ack) state_d = FLUSH_SCAN;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      lat_line_q <= '0;
      lat_tag_q  <= '0;
      vic_way_q  <= '0;
      vic_rr_q   <= 1'b0;
      fl_line_q  <= '0;
      fl_way_q   <= '0;
      proc_rdata <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        INIT: init_cnt_q <= init_cnt_q + 1'b1;
        IDLE: begin
          if (flush_req) begin
            fl_line_q <= '0;
            fl_way_q  <= '0;
          end else if (proc_cs) begin
            if (hit) begin
              if (!proc_rw) proc_rdata <= hit_word;
            end else begin
              lat_tag_q  <= p_tag;
              lat_line_q <= p_line;
              vic_way_q  <= vic_way;
              vic_rr_q   <= !inv_found;
            end
          end
        end
        // The last entry is not advanced past; the rescan sees it clean and finishes.
        FLUSH_SCAN, FLUSH_WB: begin
          if (((state_q == FLUSH_SCAN && !f_dirty) || (state_q == FLUSH_WB && mem_ack)) && !f_last) begin
            if (fl_way_q == RW'(WAYS - 1)) begin
              fl_way_q  <= '0;
              fl_line_q <= fl_line_q + 1'b1;
            end else begin
              fl_way_q <= fl_way_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      INIT: begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][init_cnt_q] <= 1'b0;
          dirty_q[w][init_cnt_q] <= 1'b0;
        end
        rr_q[init_cnt_q] <= '0;
      end
      IDLE: begin
        if (!flush_req && proc_cs && hit && proc_rw) begin
          for (int b = 0; b < BE; b++)
            if (proc_be[b])
              data_q[hit_way][p_line][p_off*WORD_WIDTH + b*8 +: 8] <= proc_wdata[b*8 +: 8];
          dirty_q[hit_way][p_line] <= 1'b1;
        end
      end
      ALLOCATE: begin
        if (mem_ack) begin
          data_q[vic_way_q][lat_line_q]  <= mem_rdata;
          valid_q[vic_way_q][lat_line_q] <= 1'b1;
          dirty_q[vic_way_q][lat_line_q] <= 1'b0;
          tag_q[vic_way_q][lat_line_q]   <= lat_tag_q;
          if (vic_rr_q) rr_q[lat_line_q] <= (WAYS > 1) ? rr_q[lat_line_q] + 1'b1 : '0;
        end
      end
      FLUSH_WB: if (mem_ack) dirty_q[fl_way_q][fl_line_q] <= 1'b0;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_assoc_wb.sv
// Randomised bench for cache_assoc_wb: a transaction-level cache/memory model predicts read data
// and the exact sequence of block fetches and write-backs seen on the memory port.
module tb_cache_assoc_wb;
  localparam int AW = 16, WW = 32, WAYS = 2, LINES = 4, BWD = 4;

  logic           clk = 1'b0;
  logic           rst, proc_cs, proc_rw, hold_cpu, flush_req, flush_done;
  logic           mem_cs, mem_rw, mem_ack;
  logic [AW-1:0]  proc_addr, mem_addr;
  logic [WW-1:0]  proc_wdata, proc_rdata;
  logic [3:0]     proc_be;
  logic [127:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cache_assoc_wb #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WAYS(WAYS), .LINES(LINES), .BLOCK_WORDS(BWD)) dut (
    .clk(clk), .rst(rst), .proc_cs(proc_cs), .proc_rw(proc_rw), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_be(proc_be), .proc_rdata(proc_rdata), .hold_cpu(hold_cpu),
    .flush_req(flush_req), .flush_done(flush_done), .mem_cs(mem_cs), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backing memory and the processor's architectural view of memory.
  logic [31:0] mem_arr [int];
  logic [31:0] gold    [int];

  function automatic logic [31:0] pat(int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction
  function automatic logic [31:0] mem_rd(int a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return pat(a);
  endfunction
  function automatic logic [31:0] gold_rd(int a);
    if (gold.exists(a)) return gold[a];
    return pat(a);
  endfunction
  function automatic logic [127:0] gold_blk(int a);
    logic [127:0] b;
    for (int i = 0; i < BWD; i++) b[i*32 +: 32] = gold_rd(a + i);
    return b;
  endfunction

  // Memory responder with random latency; logs every accepted transaction.
  bit           resp_en = 1'b1;
  int           wait_cnt = 0;
  bit           log_rw [$], e_rw [$];
  logic [15:0]  log_addr [$], e_addr [$];
  logic [127:0] log_data [$], e_data [$];

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_cs === 1'b1 && resp_en && !rst) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          log_rw.push_back(mem_rw);
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wdata);
          for (int i = 0; i < BWD; i++) begin
            if (mem_rw) mem_arr[int'(mem_addr) + i] = mem_wdata[i*32 +: 32];
            else mem_rdata[i*32 +: 32] = mem_rd(int'(mem_addr) + i);
          end
          mem_ack = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end
      end
    end
  end

  // Cache model: which block lives in which way, dirtiness and replacement pointer.
  bit   m_valid [WAYS][LINES];
  bit   m_dirty [WAYS][LINES];
  int   m_tag   [WAYS][LINES];
  int   m_rr    [LINES];
  logic [31:0] last_rd;

  task automatic model_reset();
    for (int l = 0; l < LINES; l++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[w][l] = 0;
        m_dirty[w][l] = 0;
      end
      m_rr[l] = 0;
    end
    gold = mem_arr;
    last_rd = '0;
  endtask

  task automatic expect_wb(int w, int l);
    int a = m_tag[w][l] * 16 + l * 4;
    e_rw.push_back(1'b1);
    e_addr.push_back(16'(a));
    e_data.push_back(gold_blk(a));
  endtask

  task automatic model_access(input logic [15:0] a, input bit rw, input logic [31:0] wd,
                              input logic [3:0] be, output bit miss, output logic [31:0] erd);
    int line = int'(a[3:2]);
    int tag  = int'(a[15:4]);
    int hw = -1;
    logic [31:0] nw;
    for (int w = 0; w < WAYS; w++) if (m_valid[w][line] && m_tag[w][line] == tag) hw = w;
    miss = (hw < 0);
    if (miss) begin
      int v = -1;
      bit from_rr;
      for (int w = 0; w < WAYS; w++) if (!m_valid[w][line] && v < 0) v = w;
      from_rr = (v < 0);
      if (from_rr) v = m_rr[line];
      if (m_valid[v][line] && m_dirty[v][line]) expect_wb(v, line);
      e_rw.push_back(1'b0);
      e_addr.push_back(a & 16'hFFFC);
      e_data.push_back('0);
      m_valid[v][line] = 1;
      m_dirty[v][line] = 0;
      m_tag[v][line] = tag;
      if (from_rr) m_rr[line] = (m_rr[line] + 1) % WAYS;
      hw = v;
    end
    if (rw) begin
      nw = gold_rd(int'(a));
      for (int b = 0; b < 4; b++) if (be[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
      gold[int'(a)] = nw;
      m_dirty[hw][line] = 1;
    end
    erd = gold_rd(int'(a));
  endtask

  task automatic model_flush();
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[w][l] && m_dirty[w][l]) begin
          expect_wb(w, l);
          m_dirty[w][l] = 0;
        end
  endtask

  task automatic check_traffic(input string tag);
    int n = (log_addr.size() < e_addr.size()) ? log_addr.size() : e_addr.size();
    check_eq({tag, "_nmem"}, log_addr.size(), e_addr.size());
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_mrw"}, log_rw[i], e_rw[i]);
      check_eq({tag, "_maddr"}, log_addr[i], e_addr[i]);
      if (e_rw[i]) check_eq({tag, "_mwdata"}, log_data[i], e_data[i]);
    end
    log_rw.delete(); log_addr.delete(); log_data.delete();
    e_rw.delete(); e_addr.delete(); e_data.delete();
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (hold_cpu && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({tag, "_grant_tmo"}, n < 300, 1);
  endtask

  task automatic access(input logic [15:0] a, input bit rw, input logic [31:0] wd,
                        input logic [3:0] be, input string tag);
    bit miss;
    logic [31:0] erd;
    model_access(a, rw, wd, be, miss, erd);
    @(negedge clk);
    proc_cs = 1'b1; proc_rw = rw; proc_addr = a; proc_wdata = wd; proc_be = be;
    #1;
    check_eq({tag, "_hold"}, hold_cpu, miss);
    wait_grant(tag);
    @(posedge clk);
    @(negedge clk);
    proc_cs = 1'b0;
    if (rw) check_eq({tag, "_rdhold"}, proc_rdata, last_rd);
    else begin
      check_eq({tag, "_rdata"}, proc_rdata, erd);
      last_rd = erd;
    end
    check_traffic(tag);
  endtask

  task automatic do_flush(input bit with_req, input logic [15:0] a, input string tag);
    bit miss;
    logic [31:0] erd;
    int n = 0, extra = 0;
    model_flush();
    if (with_req) model_access(a, 1'b0, '0, '0, miss, erd);
    @(negedge clk);
    flush_req = 1'b1;
    if (with_req) begin
      proc_cs = 1'b1; proc_rw = 1'b0; proc_addr = a; proc_be = '0;
    end
    #1;
    check_eq({tag, "_hold"}, hold_cpu, 1);
    while (!flush_done && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({tag, "_done_tmo"}, n < 600, 1);
    flush_req = 1'b0;
    if (with_req) begin
      wait_grant(tag);
      @(posedge clk);
      @(negedge clk);
      proc_cs = 1'b0;
      check_eq({tag, "_rdata"}, proc_rdata, erd);
      last_rd = erd;
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (flush_done) extra++;
    end
    check_eq({tag, "_extra_pulses"}, extra, 0);
    check_traffic(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; proc_cs = 1'b0; flush_req = 1'b0;
    #1;
    check_eq({tag, "_mem_cs"}, mem_cs, 0);
    check_eq({tag, "_mem_rw"}, mem_rw, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_rdata"}, proc_rdata, 0);
    check_eq({tag, "_flush_done"}, flush_done, 0);
    check_eq({tag, "_hold"}, hold_cpu, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < LINES; i++) begin
      check_eq({tag, "_init_hold"}, hold_cpu, 1);
      @(negedge clk); #1;
    end
    check_eq({tag, "_idle_hold"}, hold_cpu, 0);
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; proc_cs = 1'b0; proc_rw = 1'b0; proc_addr = '0;
    proc_wdata = '0; proc_be = '0; flush_req = 1'b0;
    for (int i = 0; i < 4; i++) mem_arr[16 + i] = 32'(i + 1);
    do_reset("rst0");

    access(16'h0010, 1'b0, '0, '0, "t1_rd");
    check_eq("t1_val", proc_rdata, 32'h1);
    access(16'h0011, 1'b1, 32'hAABBCCDD, 4'b0101, "t2_wr");
    access(16'h0011, 1'b0, '0, '0, "t2_rd");
    check_eq("t2_val", proc_rdata, 32'h00BB00DD);
    access(16'h0000, 1'b0, '0, '0, "t3_a");
    access(16'h0040, 1'b0, '0, '0, "t3_b");
    access(16'h0080, 1'b0, '0, '0, "t3_c");
    access(16'h0041, 1'b1, 32'h12345678, 4'hF, "t4_wr");
    access(16'h00C0, 1'b0, '0, '0, "t4_rd");
    access(16'h0081, 1'b1, 32'hCAFEF00D, 4'hF, "t5_wr");
    do_flush(1'b1, 16'h0010, "t5_flush");
    access(16'h0080, 1'b0, '0, '0, "t5_clean");

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) do_flush(1'b0, '0, "rnd_flush");
      else access(16'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), $urandom,
                  4'($urandom_range(0, 15)), "rnd");
    end

    do_flush(1'b0, '0, "pre_rst");
    resp_en = 1'b0;
    @(negedge clk);
    proc_cs = 1'b1; proc_rw = 1'b0; proc_addr = 16'h0104; proc_be = '0;
    #1;
    n = 0;
    while (!(mem_cs === 1'b1 && mem_rw === 1'b0) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("alloc_reach_tmo", n < 50, 1);
    do_reset("rst_mid");
    resp_en = 1'b1;
    check_traffic("rst_mid");
    access(16'h0104, 1'b0, '0, '0, "rst_reread");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
